// File: rtl/me_window_loader_if.sv
// me_window_loader_if: pixel-stream input and window-row output bundle of the search-window loader.
// Rev 1.0
`default_nettype none

interface me_window_loader_if #(
  parameter int WIN_W = 23,
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0]       pix_in;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [WIN_W*PIX_W-1:0] win_row;
  logic                   win_valid;
  logic                   win_first;
  logic                   win_last;
  logic                   busy;

  // master: the side feeding pixels and consuming window rows
  modport master (
    output pix_in, pix_valid,
    input  pix_ready, win_row, win_valid, win_first, win_last, busy
  );

  // slave: the loader itself
  modport slave (
    input  pix_in, pix_valid,
    output pix_ready, win_row, win_valid, win_first, win_last, busy
  );
endinterface

`default_nettype wire

// File: rtl/me_window_loader.sv
// me_window_loader: packs raster pixels into two window banks and bursts each as WIN_H back-to-back rows.
// Rev 1.0 | optional feature macro ME_WIN_STATS_EN adds the win_count output.
`default_nettype none

module me_window_loader #(
  parameter int WIN_W      = 23,
  parameter int WIN_H      = 23,
  parameter int PIX_W      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  wire                clk,
  input  wire                rst,
  me_window_loader_if.slave  bus
`ifdef ME_WIN_STATS_EN
  ,
  output logic [15:0]        win_count
`endif
);

  localparam int C_MAX_WH = (WIN_W > WIN_H) ? WIN_W : WIN_H;
  localparam int C_MAX    = (C_MAX_WH > GAP_CYCLES + 1) ? C_MAX_WH : GAP_CYCLES + 1;
  localparam int C_CNT_W  = $clog2(C_MAX);

  localparam logic [C_CNT_W-1:0] C_COL_LAST = C_CNT_W'(WIN_W - 1);
  localparam logic [C_CNT_W-1:0] C_ROW_LAST = C_CNT_W'(WIN_H - 1);
  localparam logic [C_CNT_W-1:0] C_GAP_LAST = C_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [C_CNT_W-1:0] C_ONE      = C_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [PIX_W-1:0]   r_mem [2][WIN_H][WIN_W];
  logic [1:0]         r_full;
  logic               r_wr_bank;
  logic [C_CNT_W-1:0] r_col;
  logic [C_CNT_W-1:0] r_row;

  state_t             r_state;
  logic               r_rd_bank;
  logic [C_CNT_W-1:0] r_rd_row;
  logic [C_CNT_W-1:0] r_gap_cnt;

  logic               w_xfer;
  logic               w_wr_done;
  logic               w_burst_done;
  logic [1:0]         w_set_full;
  logic [1:0]         w_clr_full;

  assign bus.pix_ready = ~rst & ~r_full[r_wr_bank];
  assign bus.busy      = (|r_full) | (r_state != S_IDLE);

  assign w_xfer       = bus.pix_valid & bus.pix_ready;
  assign w_wr_done    = w_xfer && (r_col == C_COL_LAST) && (r_row == C_ROW_LAST);
  assign w_burst_done = (r_state == S_BURST) && (r_rd_row == C_ROW_LAST);

  always_comb begin
    w_set_full = 2'b00;
    w_clr_full = 2'b00;
    if (w_wr_done)
      w_set_full[r_wr_bank] = 1'b1;
    if (w_burst_done)
      w_clr_full[r_rd_bank] = 1'b1;
  end

  // Write side: raster counters on the bank currently being filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
    end else if (w_xfer) begin
      r_mem[r_wr_bank][r_row][r_col] <= bus.pix_in;
      if (r_col == C_COL_LAST) begin
        r_col <= '0;
        if (r_row == C_ROW_LAST) begin
          r_row     <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_row <= r_row + C_ONE;
        end
      end else begin
        r_col <= r_col + C_ONE;
      end
    end
  end

  // Set and clear always target different banks, so both may land on one edge.
  always_ff @(posedge clk) begin
    if (rst)
      r_full <= 2'b00;
    else
      r_full <= (r_full | w_set_full) & ~w_clr_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rd_bank     <= 1'b0;
      r_rd_row      <= '0;
      r_gap_cnt     <= '0;
      bus.win_row   <= '0;
      bus.win_valid <= 1'b0;
      bus.win_first <= 1'b0;
      bus.win_last  <= 1'b0;
    end else begin
      bus.win_row   <= '0;
      bus.win_valid <= 1'b0;
      bus.win_first <= 1'b0;
      bus.win_last  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state  <= S_BURST;
            r_rd_row <= '0;
          end
        end
        S_BURST: begin
          bus.win_valid <= 1'b1;
          bus.win_first <= (r_rd_row == '0);
          bus.win_last  <= (r_rd_row == C_ROW_LAST);
          // Column 0 lands in the most significant pixel slot.
          for (int c = 0; c < WIN_W; c++)
            bus.win_row[(WIN_W-c)*PIX_W-1 -: PIX_W] <= r_mem[r_rd_bank][r_rd_row][c];
          if (r_rd_row == C_ROW_LAST) begin
            r_rd_row  <= '0;
            r_rd_bank <= ~r_rd_bank;
            r_gap_cnt <= '0;
            r_state   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            r_rd_row <= r_rd_row + C_ONE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == C_GAP_LAST)
            r_state <= S_IDLE;
          else
            r_gap_cnt <= r_gap_cnt + C_ONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ME_WIN_STATS_EN
  logic [15:0] r_win_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_win_count <= 16'h0000;
    else if (bus.win_last)
      r_win_count <= r_win_count + 16'h0001;
  end

  assign win_count = r_win_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_me_window_loader.sv
// tb_me_window_loader: table vectors, directed corner sequences and random traffic against a window-queue model.
// Rev 1.0
`default_nettype none

module tb_me_window_loader;

  localparam int GAP  = 4;
  localparam int NPIX = 529;

  logic clk = 1'b0;
  logic rst = 1'b1;

  me_window_loader_if #(.WIN_W(23), .PIX_W(8)) bus ();

`ifdef ME_WIN_STATS_EN
  logic [15:0] win_count;
`endif

  me_window_loader #(
    .WIN_W(23), .WIN_H(23), .PIX_W(8), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ME_WIN_STATS_EN
    ,
    .win_count(win_count)
`endif
  );

  always #5 clk = ~clk;

  typedef logic [7:0] win_t [NPIX];

  typedef struct {
    int         mode;
    logic [7:0] base;
    logic [7:0] r0_msb;
    logic [7:0] r0_lsb;
    logic [7:0] r22_lsb;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted pixels grouped into whole windows, emitted in order.
  win_t         win_q[$];
  int           done_q[$];
  win_t         cur_win;
  int           cur_n      = 0;
  int           ecnt       = 0;
  bit           acc_next   = 1'b0;
  bit           rst_next   = 1'b0;
  logic [7:0]   acc_pix    = 8'h00;
  bit           in_burst   = 1'b0;
  int           row_idx    = 0;
  int           first_edge = 0;
  int           last_end   = -1000;
  int           mon_row    = -1;
  int           bursts_done = 0;
  logic [183:0] got_r0     = '0;
  logic [183:0] got_r22    = '0;
  int           got_first_edge = 0;
  int           got_done_edge  = 0;

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [183:0] got, input logic [183:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_ev(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event expected none (t=%0t)", name, $time);
  endtask

  function automatic logic [183:0] exp_row(input win_t w, input int r);
    logic [183:0] v;
    v = '0;
    for (int c = 0; c < 23; c++)
      v[(23-c)*8-1 -: 8] = w[r*23+c];
    return v;
  endfunction

  function automatic logic [7:0] pixval(input int mode, input logic [7:0] base, input int k);
    case (mode)
      0:       return 8'(int'(base) + (k % NPIX));
      1:       return 8'(int'(base) * (k / NPIX + 1));
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      ecnt++;
      if (rst_next) begin
        win_q.delete();
        done_q.delete();
        cur_n    = 0;
        in_burst = 1'b0;
        last_end = -1000;
        mon_row  = -1;
        check_int("reset_ctrl", int'({bus.win_valid, bus.win_first, bus.win_last, bus.busy}), 0);
        check_vec("reset_row", bus.win_row, '0);
      end else begin
        if (acc_next) begin
          cur_win[cur_n] = acc_pix;
          cur_n++;
          if (cur_n == NPIX) begin
            win_q.push_back(cur_win);
            done_q.push_back(ecnt);
            cur_n = 0;
          end
        end
        mon_row = -1;
        if (bus.win_valid) begin
          if (!in_burst) begin
            if (win_q.size() == 0) begin
              fail_ev("spurious_row");
            end else begin
              if (last_end > 0)
                check_int("burst_gap_ok", int'((ecnt - last_end - 1) >= GAP), 1);
              in_burst   = 1'b1;
              row_idx    = 0;
              first_edge = ecnt;
            end
          end
          if (in_burst) begin
            check_vec("row_data", bus.win_row, exp_row(win_q[0], row_idx));
            check_int("row_flags", int'({bus.win_first, bus.win_last}),
                      ((row_idx == 0) ? 2 : 0) + ((row_idx == 22) ? 1 : 0));
            mon_row = row_idx;
            if (row_idx == 0)
              got_r0 = bus.win_row;
            if (row_idx == 22) begin
              got_r22        = bus.win_row;
              got_first_edge = first_edge;
              got_done_edge  = done_q[0];
              void'(win_q.pop_front());
              void'(done_q.pop_front());
              in_burst = 1'b0;
              last_end = ecnt;
              bursts_done++;
            end else begin
              row_idx++;
            end
          end
        end else begin
          if (in_burst) begin
            fail_ev("burst_broken");
            in_burst = 1'b0;
            void'(win_q.pop_front());
            void'(done_q.pop_front());
          end
          check_vec("idle_zero", {bus.win_first, bus.win_last, bus.win_row[181:0]}, '0);
        end
        if (win_q.size() > 0)
          check_int("busy_loaded", int'(bus.busy), 1);
        else if (!in_burst && (ecnt - last_end) > 10)
          check_int("busy_quiet", int'(bus.busy), 0);
      end
      check_int("pix_ready", int'(bus.pix_ready), int'(!rst && (win_q.size() < 2)));
      acc_next = !rst && bus.pix_valid && bus.pix_ready;
      acc_pix  = bus.pix_in;
      rst_next = rst;
    end
  endtask

  task automatic send(input int n, input int mode, input logic [7:0] base, input int vpct,
                      output int stalls);
    int sent;
    int budget;
    sent   = 0;
    budget = 0;
    stalls = 0;
    while (sent < n && budget < n * 8 + 1000) begin
      @(posedge clk);
      #1;
      budget++;
      if ($urandom_range(99) < vpct) begin
        bus.pix_valid = 1'b1;
        bus.pix_in    = pixval(mode, base, sent);
        if (bus.pix_ready) sent++;
        else stalls++;
      end else begin
        bus.pix_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    if (sent < n) fail_ev("send_timeout");
  endtask

  task automatic wait_bursts(input int target, input int budget);
    int t;
    t = 0;
    while (bursts_done < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (bursts_done < target) fail_ev("burst_timeout");
  endtask

  initial begin
    vec_t tbl[5];
    int   st;
    int   b;
    int   t;

    bus.pix_valid = 1'b0;
    bus.pix_in    = 8'h00;

    tbl[0] = '{mode: 0, base: 8'h00, r0_msb: 8'h00, r0_lsb: 8'h16, r22_lsb: 8'h10};
    tbl[1] = '{mode: 1, base: 8'h11, r0_msb: 8'h11, r0_lsb: 8'h11, r22_lsb: 8'h11};
    tbl[2] = '{mode: 1, base: 8'h22, r0_msb: 8'h22, r0_lsb: 8'h22, r22_lsb: 8'h22};
    tbl[3] = '{mode: 0, base: 8'hF0, r0_msb: 8'hF0, r0_lsb: 8'h06, r22_lsb: 8'h00};
    tbl[4] = '{mode: 0, base: 8'h80, r0_msb: 8'h80, r0_lsb: 8'h96, r22_lsb: 8'h90};

    fork
      monitor_loop();
    join_none

    // T1: reset held, then released
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_int("t1_rst_pix_ready", int'(bus.pix_ready), 0);
    check_int("t1_rst_win_valid", int'(bus.win_valid), 0);
    check_int("t1_rst_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_int("t1_rel_pix_ready", int'(bus.pix_ready), 1);
    check_int("t1_rel_busy", int'(bus.busy), 0);

    // T2 and table: single windows with known corner bytes and N+2 latency
    for (int i = 0; i < 5; i++) begin
      b = bursts_done;
      send(NPIX, tbl[i].mode, tbl[i].base, 100, st);
      wait_bursts(b + 1, 300);
      check_int("tbl_r0_msb", int'(got_r0[183:176]), int'(tbl[i].r0_msb));
      check_int("tbl_r0_lsb", int'(got_r0[7:0]), int'(tbl[i].r0_lsb));
      check_int("tbl_r22_lsb", int'(got_r22[7:0]), int'(tbl[i].r22_lsb));
      check_int("tbl_latency", got_first_edge - got_done_edge, 2);
    end

    // T3: two windows back to back
    b = bursts_done;
    send(2 * NPIX, 1, 8'h11, 100, st);
    check_int("t3_stalls", st, 0);
    wait_bursts(b + 2, 300);
    check_int("t3_second_fill", int'(got_r0[183:176]), 8'h22);

    // T4: three windows continuous, random data
    b = bursts_done;
    send(3 * NPIX, 2, 8'h00, 100, st);
    wait_bursts(b + 3, 300);
    check_int("t4_bursts", bursts_done, b + 3);

    // Random valid gaps and data
    b = bursts_done;
    send(3 * NPIX, 2, 8'h00, 70, st);
    wait_bursts(b + 3, 300);
    check_int("rnd_bursts", bursts_done, b + 3);

    // T5: reset lands while row 10 is on the output
    b = bursts_done;
    send(NPIX, 0, 8'h40, 100, st);
    t = 0;
    while (mon_row != 9 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (mon_row != 9) fail_ev("t5_row10_timeout");
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_int("t5_valid_after_rst", int'(bus.win_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    check_int("t5_no_tail_rows", bursts_done, b);
    send(NPIX, 0, 8'h00, 100, st);
    wait_bursts(b + 1, 300);
    check_int("t5_fresh_r0_msb", int'(got_r0[183:176]), 8'h00);
    check_int("t5_fresh_r0_lsb", int'(got_r0[7:0]), 8'h16);

`ifdef ME_WIN_STATS_EN
    // T6: burst counter
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    b = bursts_done;
    send(3 * NPIX, 2, 8'h00, 100, st);
    wait_bursts(b + 3, 300);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("t6_count3", int'(win_count), 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("t6_count_rst", int'(win_count), 0);
    force dut.r_win_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_win_count;
    b = bursts_done;
    send(NPIX, 0, 8'h00, 100, st);
    wait_bursts(b + 1, 300);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("t6_count_wrap", int'(win_count), 0);
`endif

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
